// File: rtl/mpuc_pkg.sv
// Shared types and defaults for the MPUC sample sequencer.
// Holds the FSM state enum and the {valid, index} latency-pipe entry.
package mpuc_pkg;

  localparam int MPY_LAT_DEF = 3;
  localparam int IDX_W_MAX   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic                 vld;
    logic [IDX_W_MAX-1:0] idx;
  } lat_entry_t;

  function automatic lat_entry_t make_entry(input logic vld,
                                            input logic [IDX_W_MAX-1:0] idx);
    lat_entry_t e;
    e.vld = vld;
    e.idx = idx;
    return e;
  endfunction

endpackage

// File: rtl/mpuc_lat_pipe.sv
// Shift register of {valid, index} entries mirroring the multiplier latency.
// Advances only when EN is high; CLR empties it synchronously.
module mpuc_lat_pipe
  import mpuc_pkg::*;
#(
  parameter int DEPTH = MPY_LAT_DEF
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       EN,
  input  lat_entry_t D,
  output lat_entry_t Q,
  output logic       EMPTY
);

  lat_entry_t stage [DEPTH];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (EN) begin
      stage[0] <= D;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign Q = stage[DEPTH-1];

  always_comb begin
    EMPTY = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage[i].vld) EMPTY = 1'b0;
    end
  end

endmodule

// File: rtl/mpuc_seq.sv
// Frame sequencer for the time-multiplexed constant multiplier (one DS per complex sample).
// Optional performance counters are built when MPUC_SEQ_PERF_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for START, multiplier disabled
// ST_RUN   | accepting samples, one DS per accepted sample
// ST_FLUSH | all N samples issued, draining the latency pipe
module mpuc_seq
  import mpuc_pkg::*;
#(
  parameter int TOTAL_BITS = 32,
  parameter int LOG_N      = 4,
  parameter int MPY_LAT    = MPY_LAT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  IN_VLD,
  output logic                  IN_RDY,
  input  logic [TOTAL_BITS-1:0] IN_DR,
  input  logic [TOTAL_BITS-1:0] IN_DI,
  output logic                  MPY_ED,
  output logic                  MPY_DS,
  output logic                  MPY_J,
  output logic [TOTAL_BITS-1:0] MPY_DR,
  output logic [TOTAL_BITS-1:0] MPY_DI,
  output logic                  OUT_VLD,
  output logic [LOG_N-1:0]      OUT_IDX,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  DONE
`ifdef MPUC_SEQ_PERF_EN
  ,
  output logic [15:0]           STALL_CNT,
  output logic [15:0]           FRAME_CNT
`endif
);

  seq_state_e       state, state_nxt;
  logic [LOG_N-1:0] k;
  logic [LOG_N-1:0] ds_idx;
  logic             phase;
  logic             accept;
  logic             done_nxt;
  lat_entry_t       pipe_d, pipe_q;
  logic             pipe_empty;
  logic             unused_ok;

  assign accept = IN_VLD & IN_RDY;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    MPY_ED    = 1'b0;
    IN_RDY    = 1'b0;
    BUSY      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        MPY_ED = 1'b1;
        BUSY   = 1'b1;
        IN_RDY = ~phase;
        // k has already wrapped to 0 only on the DS cycle of the last sample
        if (phase && (k == '0)) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        MPY_ED = 1'b1;
        BUSY   = 1'b1;
        if (pipe_empty) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k      <= '0;
      phase  <= 1'b0;
      ds_idx <= '0;
      MPY_DS <= 1'b0;
      MPY_J  <= 1'b0;
      MPY_DR <= '0;
      MPY_DI <= '0;
      DONE   <= 1'b0;
    end else begin
      DONE   <= done_nxt;
      MPY_DS <= accept;
      phase  <= accept;
      if (state == ST_IDLE && START) begin
        k <= '0;
      end else if (accept) begin
        k      <= k + LOG_N'(1);
        ds_idx <= k;
        MPY_DR <= IN_DR;
        MPY_DI <= IN_DI;
        MPY_J  <= k[LOG_N-1];
      end
    end
  end

  // The pipe samples DS on the same edge the multiplier does; the output
  // register below adds the final edge so OUT_VLD lines up with DOR/DOI.
  assign pipe_d = make_entry(MPY_DS, IDX_W_MAX'(ds_idx));

  mpuc_lat_pipe #(
    .DEPTH (MPY_LAT)
  ) u_lat_pipe (
    .CLK   (CLK),
    .CLR   (RST),
    .EN    (MPY_ED),
    .D     (pipe_d),
    .Q     (pipe_q),
    .EMPTY (pipe_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VLD <= 1'b0;
      OUT_IDX <= '0;
    end else if (MPY_ED) begin
      OUT_VLD <= pipe_q.vld;
      OUT_IDX <= pipe_q.idx[LOG_N-1:0];
    end
  end

  assign OUT_LAST  = OUT_VLD & (OUT_IDX == {LOG_N{1'b1}});
  assign unused_ok = &{1'b0, pipe_q.idx};

`ifdef MPUC_SEQ_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CNT <= '0;
      FRAME_CNT <= '0;
    end else begin
      if (state == ST_IDLE && START) begin
        STALL_CNT <= '0;
      end else if (state == ST_RUN && !phase && !IN_VLD && STALL_CNT != 16'hFFFF) begin
        STALL_CNT <= STALL_CNT + 16'd1;
      end
      if (done_nxt) FRAME_CNT <= FRAME_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mpuc_seq.sv
// Randomized bench for mpuc_seq against a transaction-level timing model.
module tb_mpuc_seq;

  localparam int TB  = 32;
  localparam int LN  = 4;
  localparam int N   = 16;
  localparam int LAT = 3;

  logic          CLK = 1'b0;
  logic          RST, START, IN_VLD;
  logic [TB-1:0] IN_DR, IN_DI;
  logic          IN_RDY, MPY_ED, MPY_DS, MPY_J;
  logic [TB-1:0] MPY_DR, MPY_DI;
  logic          OUT_VLD, OUT_LAST, BUSY, DONE;
  logic [LN-1:0] OUT_IDX;
`ifdef MPUC_SEQ_PERF_EN
  logic [15:0]   STALL_CNT, FRAME_CNT;
`endif

  mpuc_seq #(.TOTAL_BITS(TB), .LOG_N(LN), .MPY_LAT(LAT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .IN_VLD   (IN_VLD),
    .IN_RDY   (IN_RDY),
    .IN_DR    (IN_DR),
    .IN_DI    (IN_DI),
    .MPY_ED   (MPY_ED),
    .MPY_DS   (MPY_DS),
    .MPY_J    (MPY_J),
    .MPY_DR   (MPY_DR),
    .MPY_DI   (MPY_DI),
    .OUT_VLD  (OUT_VLD),
    .OUT_IDX  (OUT_IDX),
    .OUT_LAST (OUT_LAST),
    .BUSY     (BUSY),
    .DONE     (DONE)
`ifdef MPUC_SEQ_PERF_EN
    ,
    .STALL_CNT(STALL_CNT),
    .FRAME_CNT(FRAME_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // model: cycle numbers at which each observable event must happen
  int          t;
  bit          m_busy;
  int          busy_from, rdy_from, ds_at, done_at, acc_n, out_ptr, last_acc;
  int          out_cyc [N];
  logic [TB-1:0] h_dr, h_di;
  bit          h_j;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    busy_from = 0;
    rdy_from  = 0;
    ds_at     = -1;
    done_at   = -1;
    acc_n     = 0;
    out_ptr   = 0;
    last_acc  = -10;
    h_dr      = '0;
    h_di      = '0;
    h_j       = 1'b0;
  endtask

  task automatic cyc(input bit start, input bit rst, input bit vld, output int acc_idx);
    bit eb, er, ev;
    int ei;
    @(negedge CLK);
    t++;
    if (t == done_at) m_busy = 1'b0;
    eb = m_busy && (t >= busy_from);
    er = eb && (acc_n < N) && (t >= rdy_from);
    ev = (out_ptr < acc_n) && (out_cyc[out_ptr] == t);
    ei = ev ? out_ptr : 0;

    chk("busy",    BUSY,    eb);
    chk("mpy_ed",  MPY_ED,  eb);
    chk("in_rdy",  IN_RDY,  er);
    chk("mpy_ds",  MPY_DS,  (t == ds_at));
    chk("mpy_j",   MPY_J,   h_j);
    chk("mpy_dr",  MPY_DR,  h_dr);
    chk("mpy_di",  MPY_DI,  h_di);
    chk("out_vld", OUT_VLD, ev);
    if (ev) chk("out_idx", OUT_IDX, ei);
    chk("out_last", OUT_LAST, ev && (ei == N-1));
    chk("done",    DONE,    (t == done_at));
    if (ev) out_ptr++;

    START  = start;
    RST    = rst;
    IN_VLD = vld;
    IN_DR  = $urandom;
    IN_DI  = $urandom;
    acc_idx = -1;
    if (rst) begin
      model_reset();
    end else begin
      if (start && !eb) begin
        m_busy    = 1'b1;
        busy_from = t + 1;
        rdy_from  = t + 1;
        acc_n     = 0;
        out_ptr   = 0;
        ds_at     = -1;
        done_at   = -1;
      end
      if (vld && er) begin
        acc_idx        = acc_n;
        out_cyc[acc_n] = t + LAT + 2;
        ds_at          = t + 1;
        rdy_from       = t + 2;
        last_acc       = t;
        h_dr           = IN_DR;
        h_di           = IN_DI;
        h_j            = (acc_n >= N/2);
        if (acc_n == N-1) done_at = t + LAT + 3;
        acc_n++;
      end
    end
  endtask

  // mode: 0 full rate, 1 fixed gaps, 2 START mid-run, 3 random valid, 4 reset in flush
  task automatic run_frame(input int mode, input int idle_pre);
    int a, gap;
    bit vld, st, r;
    for (int i = 0; i < idle_pre; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), a);
    cyc(1'b1, 1'b0, 1'b1, a);
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      vld = (mode == 3) ? 1'($urandom_range(0, 1)) : (gap == 0);
      if (gap > 0) gap--;
      st = (mode == 2) && (acc_n == 6);
      r  = (mode == 4) && (acc_n == N) && (t + 1 == last_acc + 2);
      cyc(st, r, vld, a);
      if (mode == 1 && a == 3)  gap = 5;
      if (mode == 1 && a == 10) gap = 1;
      if (r) begin
        for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), a);
        return;
      end
      if (t == done_at) begin
        cyc(1'b0, 1'b0, 1'b0, a);
        return;
      end
    end
    chk("frame_timeout", 1, 0);
  endtask

  initial begin
    int a;
    RST    = 1'b1;
    START  = 1'b0;
    IN_VLD = 1'b0;
    IN_DR  = '0;
    IN_DI  = '0;
    t      = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    cyc(1'b0, 1'b1, 1'b0, a);
    cyc(1'b0, 1'b0, 1'b0, a);

    run_frame(0, 2);
    run_frame(1, 1);
    run_frame(2, 0);
    for (int f = 0; f < 3; f++) run_frame(3, int'($urandom_range(0, 4)));
    run_frame(4, 1);
    run_frame(0, 2);

    // START and RST together: reset wins, nothing starts
    cyc(1'b1, 1'b1, 1'b1, a);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, a);
    run_frame(3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpuc_seq.md
Name: mpuc_seq

Overview:
- Sequencer that feeds a frame of complex samples into the time-multiplexed constant multiplier (MPUC1307-class: one DS pulse per complex sample, real part processed on the DS cycle, imaginary part on the next).
- Accepts samples over a valid/ready handshake and issues DS/ED/MPYJ with the held operands. MPYJ follows a per-frame index pattern.
- Tracks the multiplier latency to flag result validity, index and end-of-frame.
- Sits between the FFT stage buffer and the multiplier.

Parameters:
- TOTAL_BITS, 32, sample word width; matches multiplier total_bits.
- LOG_N, 4, log2 of samples per frame (N = 2^LOG_N).
- MPY_LAT, 3, enabled edges from the DS-sampling edge until DOR/DOI hold that sample's result.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- START  in  1  frame start pulse; honoured only in IDLE
- IN_VLD  in  1  input sample valid
- IN_RDY  out  1  sequencer can accept a sample
- IN_DR  in  TOTAL_BITS  input real part
- IN_DI  in  TOTAL_BITS  input imaginary part
- MPY_ED  out  1  to multiplier ED
- MPY_DS  out  1  to multiplier DS
- MPY_J  out  1  to multiplier MPYJ
- MPY_DR  out  TOTAL_BITS  to multiplier DR (held operand)
- MPY_DI  out  TOTAL_BITS  to multiplier DI (held operand)
- OUT_VLD  out  1  multiplier DOR/DOI hold a valid result this cycle
- OUT_IDX  out  LOG_N  frame index of the result on OUT_VLD
- OUT_LAST  out  1  OUT_VLD result is index N-1
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. All state is registered on posedge CLK.
- Reset values:
  - All outputs 0; state IDLE.
  - Index counter k=0; phase=0; latency delay line cleared.
  - Reset mid-frame aborts the frame. No DONE is issued, and no OUT_VLD appears for in-flight samples.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - MPY_ED=0, IN_RDY=0.
  - START=1 moves to RUN next cycle with k=0, phase=0.
- RUN:
  - MPY_ED=1 continuously.
  - IN_RDY=1 iff phase=0.
  - Accept (IN_VLD&IN_RDY) in cycle c:
    - IN_DR/IN_DI are registered to MPY_DR/MPY_DI.
    - MPY_J <= k[LOG_N-1] (second half of the frame is multiplied by -j).
    - MPY_DS=1 in cycle c+1; phase=1 in c+1; phase=0 in c+2.
  - Maximum throughput is therefore one sample per 2 cycles.
  - MPY_DR/MPY_DI/MPY_J hold their values until the next accept.
  - With no accept in phase 0, MPY_DS=0 and the state is unchanged. Gaps of any length are allowed.
  - On accepting k=N-1, go to FLUSH after the DS cycle. k wraps to 0.
- FLUSH:
  - MPY_ED=1, IN_RDY=0.
  - Wait until the delay line is empty.
  - Then DONE=1 for one cycle and return to IDLE (BUSY=0 in the same cycle as DONE).
- Result tracking:
  - Delay line of depth MPY_LAT carries {valid, index}, advanced only when MPY_ED=1.
  - OUT_VLD asserts exactly in the cycle the multiplier first presents that sample's DOR/DOI.
  - Default: a DS sampled at edge e gives OUT_VLD in the cycle after edge e+3.
  - OUT_LAST = OUT_VLD & (OUT_IDX==N-1).
- START while BUSY is ignored. START and RST together: RST wins.
- IN_VLD while IN_RDY=0 is not consumed; the source holds the data.
- Exactly N OUT_VLD pulses per frame, in index order 0..N-1.

Optional Feature:
- MPUC_SEQ_PERF_EN
  - Defined:
    - Adds output STALL_CNT [15:0], cleared on START, saturating.
    - Increments each RUN cycle with phase=0 and IN_VLD=0.
    - Adds output FRAME_CNT [15:0], incremented on DONE, wrapping.
  - Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package mpuc_pkg:
  - State enum (IDLE, RUN, FLUSH).
  - Default MPY_LAT constant.
  - Typedef for the {valid, index} delay-line entry.
- One natural sub-module: mpuc_lat_pipe. Parameterised shift register of {valid, index}, with enable and synchronous clear.

Test Plan:
- Reset then START, LOG_N=4, IN_VLD held 1:
  - IN_RDY alternates 1/0.
  - 16 MPY_DS pulses 2 cycles apart.
  - MPY_J=0 for k=0..7, 1 for k=8..15.
  - OUT_VLD follows each DS by 3 edges; OUT_IDX 0..15.
  - OUT_LAST on idx 15; DONE 1 cycle after the last OUT_VLD; BUSY drops with DONE.
- IN_VLD gaps: drop IN_VLD for 5 cycles after k=3 and 1 cycle after k=10:
  - No DS during the gaps; MPY_DR/MPY_DI stable.
  - Still exactly 16 ordered OUT_VLD.
- START pulsed during RUN at k=6: ignored, k continues to 7; a single DONE.
- RST asserted in FLUSH with 2 results in flight:
  - Outputs 0 next cycle; no OUT_VLD or DONE afterwards.
  - A new START runs a clean frame.
- With the multiplier instantiated, DR=1000, DI=0, k=9:
  - Result has DOR≈0, DOI≈-(1000×1.3066)/8 scaling per multiplier.
  - Check OUT_VLD aligns to the DOR/DOI update cycle.
- With MPUC_SEQ_PERF_EN: the gap scenario gives STALL_CNT=6 and FRAME_CNT=1 after DONE.
